// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: ALU control codes, opcodes, funct codes
// and instruction field positions used by the decode stage.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file with r0 hardwired to zero and a
// write-through bypass so a same-cycle read sees the data being written.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic              wr_s;

    assign wr_s = we && (waddr != {AW{1'b0}});

    // Next-state of the array: at most one entry updated per cycle
    always_comb begin
        regs_d = regs_q;
        if (wr_s) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d = regs_q;
        end
    end

    // Array storage; reset wipes every entry and drops the pending write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports with r0 forced to zero and same-cycle write forwarding
    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
        if (raddr_a == {AW{1'b0}}) begin
            rdata_a = {DATA_W{1'b0}};
        end else if (wr_s && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end else begin
            rdata_a = regs_q[raddr_a];
        end
        if (raddr_b == {AW{1'b0}}) begin
            rdata_b = {DATA_W{1'b0}};
        end else if (wr_s && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end else begin
            rdata_b = regs_q[raddr_b];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS32 R/I-type decode and operand fetch feeding a 3-bit-control ALU
// through a registered ID/EX stage with valid/ready handshaking.
module decode_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [2:0]        alu_ctrl,
    output logic [4:0]        dest_reg,
    output logic              reg_write,
    output logic              illegal,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [4:0]        rs_s;
    logic [4:0]        rt_s;
    logic [4:0]        rd_s;
    logic [15:0]       imm_s;
    logic [4:0]        unused_shamt_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;

    logic [DATA_W-1:0] dec_a_s;
    logic [DATA_W-1:0] dec_b_s;
    alu_op_e           dec_ctrl_s;
    logic [4:0]        dec_dest_s;
    logic              dec_legal_s;
    logic              accept_s;

    logic              out_valid_d, out_valid_q;
    logic [DATA_W-1:0] op_a_d, op_a_q;
    logic [DATA_W-1:0] op_b_d, op_b_q;
    logic [2:0]        alu_ctrl_d, alu_ctrl_q;
    logic [4:0]        dest_reg_d, dest_reg_q;
    logic              reg_write_d, reg_write_q;
    logic              illegal_d, illegal_q;

    assign opcode_s       = instr[OPC_HI:OPC_LO];
    assign funct_s        = instr[FUNCT_HI:FUNCT_LO];
    assign rs_s           = instr[RS_HI:RS_LO];
    assign rt_s           = instr[RT_HI:RT_LO];
    assign rd_s           = instr[RD_HI:RD_LO];
    assign imm_s          = instr[IMM_HI:IMM_LO];
    assign unused_shamt_s = instr[SHAMT_HI:SHAMT_LO];

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_s),
        .raddr_b (rt_s),
        .rdata_a (rs_val_s),
        .rdata_b (rt_val_s)
    );

    // Instruction decode; anything not matched stays an all-zero illegal op
    always_comb begin
        dec_a_s     = {DATA_W{1'b0}};
        dec_b_s     = {DATA_W{1'b0}};
        dec_ctrl_s  = ALU_ADD;
        dec_dest_s  = 5'd0;
        dec_legal_s = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                dec_a_s     = rs_val_s;
                dec_b_s     = rt_val_s;
                dec_dest_s  = rd_s;
                dec_legal_s = 1'b1;
                case (funct_s)
                    F_ADD:  dec_ctrl_s = ALU_ADD;
                    F_SUB:  dec_ctrl_s = ALU_SUB;
                    F_AND:  dec_ctrl_s = ALU_AND;
                    F_OR:   dec_ctrl_s = ALU_OR;
                    F_XOR:  dec_ctrl_s = ALU_XOR;
                    F_SLLV, F_SRLV: begin
                        // Variable shifts: value comes from rt, amount from rs
                        dec_ctrl_s = (funct_s == F_SLLV) ? ALU_SLL : ALU_SRL;
                        dec_a_s    = rt_val_s;
                        dec_b_s    = {{(DATA_W-5){1'b0}}, rs_val_s[4:0]};
                    end
                    default: begin
                        dec_a_s     = {DATA_W{1'b0}};
                        dec_b_s     = {DATA_W{1'b0}};
                        dec_dest_s  = 5'd0;
                        dec_legal_s = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_a_s     = rs_val_s;
                dec_b_s     = {{(DATA_W-16){imm_s[15]}}, imm_s};
                dec_ctrl_s  = ALU_ADD;
                dec_dest_s  = rt_s;
                dec_legal_s = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                dec_a_s     = rs_val_s;
                dec_b_s     = {{(DATA_W-16){1'b0}}, imm_s};
                dec_ctrl_s  = (opcode_s == OP_ANDI) ? ALU_AND :
                              (opcode_s == OP_ORI)  ? ALU_OR  : ALU_XOR;
                dec_dest_s  = rt_s;
                dec_legal_s = 1'b1;
            end
            default: begin
                dec_legal_s = 1'b0;
            end
        endcase
    end

    assign instr_ready = !out_valid_q || out_ready;
    assign accept_s    = instr_valid && instr_ready;

    // ID/EX register next-state: load on accept, retire on consume, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        alu_ctrl_d  = alu_ctrl_q;
        dest_reg_d  = dest_reg_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            op_a_d      = dec_a_s;
            op_b_d      = dec_b_s;
            alu_ctrl_d  = dec_ctrl_s;
            dest_reg_d  = dec_dest_s;
            reg_write_d = dec_legal_s && (dec_dest_s != 5'd0);
            illegal_d   = !dec_legal_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            op_a_q      <= {DATA_W{1'b0}};
            op_b_q      <= {DATA_W{1'b0}};
            alu_ctrl_q  <= 3'b000;
            dest_reg_q  <= 5'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            alu_ctrl_q  <= alu_ctrl_d;
            dest_reg_q  <= dest_reg_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign dest_reg  = dest_reg_q;
    assign reg_write = reg_write_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference register file and decoder
// predict each accepted op, which is compared when it reaches the output.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic [4:0]  d;
        logic        w;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  alu_ctrl;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    logic        exp_valid;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_ctrl    (alu_ctrl),
        .dest_reg    (dest_reg),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return mregs[idx];
    endfunction

    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        logic [31:0] rs_v;
        logic [31:0] rt_v;
        e    = '0;
        rs_v = mread(w[25:21]);
        rt_v = mread(w[20:16]);
        case (w[31:26])
            6'h00: begin
                e.a = rs_v; e.b = rt_v; e.d = w[15:11];
                case (w[5:0])
                    6'h20: e.c = 3'b000;
                    6'h22: e.c = 3'b001;
                    6'h24: e.c = 3'b010;
                    6'h25: e.c = 3'b011;
                    6'h26: e.c = 3'b100;
                    6'h04: begin e.c = 3'b101; e.a = rt_v; e.b = {27'd0, rs_v[4:0]}; end
                    6'h06: begin e.c = 3'b110; e.a = rt_v; e.b = {27'd0, rs_v[4:0]}; end
                    default: begin e = '0; e.ill = 1'b1; end
                endcase
            end
            6'h08: begin e.a = rs_v; e.b = {{16{w[15]}}, w[15:0]}; e.c = 3'b000; e.d = w[20:16]; end
            6'h0C: begin e.a = rs_v; e.b = {16'd0, w[15:0]}; e.c = 3'b010; e.d = w[20:16]; end
            6'h0D: begin e.a = rs_v; e.b = {16'd0, w[15:0]}; e.c = 3'b011; e.d = w[20:16]; end
            6'h0E: begin e.a = rs_v; e.b = {16'd0, w[15:0]}; e.c = 3'b100; e.d = w[20:16]; end
            default: begin e = '0; e.ill = 1'b1; end
        endcase
        e.w = !e.ill && (e.d != 5'd0);
        return e;
    endfunction

    task automatic cmp_out(input exp_t e);
        chk("op_a", op_a, e.a);
        chk("op_b", op_b, e.b);
        chk("alu_ctrl", {29'd0, alu_ctrl}, {29'd0, e.c});
        chk("reg_write", {31'd0, reg_write}, {31'd0, e.w});
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
        if (!e.ill) chk("dest_reg", {27'd0, dest_reg}, {27'd0, e.d});
    endtask

    // One clock: inputs are already driven; check, update model, advance to next negedge
    task automatic cyc(output bit acc);
        bit rdy;
        #1;
        acc = 1'b0;
        if (!rst_n) begin
            sb.delete();
            exp_valid = 1'b0;
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            @(posedge clk);
            #1;
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_op_a", op_a, 32'd0);
            chk("rst_op_b", op_b, 32'd0);
            chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
            chk("rst_dest_reg", {27'd0, dest_reg}, 32'd0);
            chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
            chk("rst_illegal", {31'd0, illegal}, 32'd0);
            @(negedge clk);
            return;
        end
        rdy = !exp_valid || out_ready;
        chk("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                cmp_out(sb[0]);
                if (out_ready) void'(sb.pop_front());
            end
        end
        acc = instr_valid && rdy;
        if (acc) sb.push_back(model(instr));
        exp_valid = acc ? 1'b1 : (out_ready ? 1'b0 : exp_valid);
        if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] w);
        bit acc;
        int tries;
        instr       = w;
        instr_valid = 1'b1;
        tries       = 0;
        acc         = 1'b0;
        while (!acc && tries < 20) begin
            cyc(acc);
            tries++;
            wb_en = 1'b0;
        end
        if (!acc) chk("issue_timeout", 32'd0, 32'd1);
        instr_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bit acc;
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        cyc(acc);
        wb_en = 1'b0;
    endtask

    initial begin
        bit          acc;
        logic [31:0] w;
        logic [5:0]  ops [11];
        rst_n = 1'b0; instr = 32'd0; instr_valid = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        exp_valid = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        @(negedge clk);
        cyc(acc);
        cyc(acc);
        rst_n = 1'b1;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);
        issue(32'h00221820);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_a", op_a, 32'd5);
        chk("add_b", op_b, 32'd3);
        chk("add_dest", {27'd0, dest_reg}, 32'd3);
        chk("add_rw", {31'd0, reg_write}, 32'd1);

        issue(32'h2004FFFF);
        chk("addi_b", op_b, 32'hFFFFFFFF);
        issue(32'h3404FFFF);
        chk("ori_b", op_b, 32'h0000FFFF);
        chk("ori_ctrl", {29'd0, alu_ctrl}, 32'd3);

        wb(5'd1, 32'h24);
        issue(32'h00222804);
        chk("sllv_a", op_a, 32'd3);
        chk("sllv_b", op_b, 32'd4);
        chk("sllv_ctrl", {29'd0, alu_ctrl}, 32'd5);

        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAA;
        issue(32'h00211820);
        chk("byp_a", op_a, 32'hAA);
        chk("byp_b", op_b, 32'hAA);
        wb(5'd0, 32'h55);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h77;
        issue(32'h00001820);
        chk("r0_a", op_a, 32'd0);
        chk("r0_b", op_b, 32'd0);

        // Stall: first op held, second must wait and then arrive exactly once
        cyc(acc);
        out_ready = 1'b0;
        issue(32'h38260F0F);
        instr = 32'h304700FF; instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(acc);
            chk("stall_acc", {31'd0, acc}, 32'd0);
            chk("stall_hold_b", op_b, 32'h00000F0F);
        end
        out_ready = 1'b1;
        cyc(acc);
        chk("release_acc", {31'd0, acc}, 32'd1);
        instr_valid = 1'b0;
        chk("second_b", op_b, 32'h000000FF);
        chk("second_ctrl", {29'd0, alu_ctrl}, 32'd2);

        issue(32'hFC000000);
        chk("ill_flag", {31'd0, illegal}, 32'd1);
        chk("ill_rw", {31'd0, reg_write}, 32'd0);
        chk("ill_valid", {31'd0, out_valid}, 32'd1);
        issue(32'h0022183F);
        chk("ill_funct", {31'd0, illegal}, 32'd1);

        ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06, 6'h08, 6'h0C, 6'h0D, 6'h0E};
        for (int i = 0; i < 80; i++) begin
            int k;
            k = $urandom_range(0, 11);
            w = $urandom;
            if (k < 7) begin
                w[31:26] = 6'h00; w[5:0] = ops[k];
            end else if (k < 11) begin
                w[31:26] = ops[k];
            end
            instr       = w;
            instr_valid = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            wb_en       = ($urandom_range(0, 1) != 0);
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            cyc(acc);
        end
        instr_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        cyc(acc);

        // Reset while an op is stalled; a same-cycle writeback must be dropped
        wb(5'd1, 32'h1234);
        out_ready = 1'b0;
        issue(32'h00211820);
        rst_n = 1'b0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hBEEF;
        cyc(acc);
        rst_n = 1'b1; wb_en = 1'b0; out_ready = 1'b1;
        issue(32'h00211820);
        chk("post_rst_r1", op_a, 32'd0);
        cyc(acc);
        cyc(acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
